// File: rtl/dense_act_serializer.sv
// dense_act_serializer
//
// Sits directly downstream of a dense layer. A single-cycle vld_in pulse
// captures the whole parallel result vector, applies the activation
// (optional ReLU, arithmetic right shift, signed saturation) and buffers the
// result. The buffer is then streamed OUTPUT_SIZE words per beat over a
// vld/rdy handshake into the next dense layer.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   vld_in    single-cycle pulse, data_in holds a complete vector
//   data_in   INPUT_SIZE signed words of BW_IN bits (word k at data_in[k])
//   rdy_out   downstream accepts the current beat
//   vld_out   data_out holds a valid beat
//   data_out  OUTPUT_SIZE signed words of BW_OUT bits (word j at data_out[j])
//   busy      a vector is held and being streamed
//   overflow  sticky, a vector arrived while the buffer was occupied
module dense_act_serializer #(
  parameter int INPUT_SIZE  = 128,
  parameter int OUTPUT_SIZE = 4,
  parameter int BW_IN       = 16,
  parameter int BW_OUT      = 16,
  parameter int R_SHIFT     = 0,
  parameter int USE_RELU    = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 vld_in,
  input  logic [INPUT_SIZE-1:0][BW_IN-1:0]     data_in,
  input  logic                                 rdy_out,
  output logic                                 vld_out,
  output logic [OUTPUT_SIZE-1:0][BW_OUT-1:0]   data_out,
  output logic                                 busy,
  output logic                                 overflow
);

  localparam int NUM_BEATS = INPUT_SIZE / OUTPUT_SIZE;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);
  localparam int SAT_MAX   = (1 << (BW_OUT - 1)) - 1;
  localparam int SAT_MIN   = -(1 << (BW_OUT - 1));

  typedef logic [OUTPUT_SIZE-1:0][BW_OUT-1:0] beat_t;
  typedef beat_t [NUM_BEATS-1:0] vec_t;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  vec_t              buffer_q, buffer_d;
  beat_t             data_out_q, data_out_d;
  logic              overflow_q, overflow_d;

  vec_t              act_vec;
  logic [CNT_W-1:0]  next_cnt;
  logic              xfer;
  logic              last_xfer;

  // ReLU, then arithmetic shift, then clamp into the BW_OUT signed range.
  function automatic logic [BW_OUT-1:0] activate(input logic [BW_IN-1:0] w);
    logic signed [BW_IN-1:0] a;
    logic signed [BW_IN-1:0] s;
    a = ((USE_RELU != 0) && w[BW_IN-1]) ? '0 : $signed(w);
    s = a >>> R_SHIFT;
    if (int'(s) > SAT_MAX) begin
      activate = BW_OUT'(SAT_MAX);
    end else if (int'(s) < SAT_MIN) begin
      activate = BW_OUT'(SAT_MIN);
    end else begin
      activate = s[BW_OUT-1:0];
    end
  endfunction

  // The whole incoming vector is activated in parallel and stored already
  // grouped into beats, so streaming is just a beat-indexed read.
  always_comb begin
    act_vec = '0;
    for (int b = 0; b < NUM_BEATS; b++) begin
      for (int j = 0; j < OUTPUT_SIZE; j++) begin
        act_vec[b][j] = activate(data_in[b*OUTPUT_SIZE + j]);
      end
    end
  end

  assign xfer      = (state_q == STREAM) && rdy_out;
  assign last_xfer = xfer && (beat_cnt_q == LAST_BEAT);
  assign next_cnt  = beat_cnt_q + CNT_W'(1);

  // Next-state logic. data_out is a register loaded with the beat about to
  // be presented, so it only moves on a capture or a transfer.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    buffer_d   = buffer_q;
    data_out_d = data_out_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (vld_in) begin
          buffer_d   = act_vec;
          data_out_d = act_vec[0];
          beat_cnt_d = '0;
          state_d    = STREAM;
        end
      end

      STREAM: begin
        if (last_xfer) begin
          beat_cnt_d = '0;
          if (vld_in) begin
            // back-to-back: new vector replaces the one just finished
            buffer_d   = act_vec;
            data_out_d = act_vec[0];
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) begin
            beat_cnt_d = next_cnt;
            data_out_d = buffer_q[next_cnt];
          end
          if (vld_in) begin
            overflow_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      buffer_q   <= '0;
      data_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      buffer_q   <= buffer_d;
      data_out_q <= data_out_d;
      overflow_q <= overflow_d;
    end
  end

  assign vld_out  = (state_q == STREAM);
  assign busy     = (state_q == STREAM);
  assign data_out = data_out_q;
  assign overflow = overflow_q;

endmodule
